bp_update_controller: RTL and testbench

Sequencer between the fetch stage, the 1-bit branch predictor table and the execute-stage branch resolver. Each fetched branch looks up the predictor. The controller records every issued prediction in an in-order tracking FIFO and pops the oldest entry when execute resolves a branch. On each pop it drives a one-cycle update (address, actual outcome) into the predictor table, and on a mispredict it asserts a pipeline flush and discards all younger in-flight predictions.

---
 rtl/bp_pkg.sv | 11 +
 rtl/bp_track_fifo.sv | 37 +++
 rtl/bp_update_controller.sv | 90 +++++++++
 tb/tb_bp_update_controller.sv | 164 ++++++++++++++++
 4 files changed

// File: rtl/bp_pkg.sv
// bp_pkg: shared defaults, controller state and tracking entry layout for the branch update controller
package bp_pkg;
  localparam int ADDR_W_D = 3;
  localparam int DEPTH_D = 4;
  localparam int CNT_W_D = 16;
  typedef enum logic {RUN, RECOVER} state_t;
  typedef struct packed {
    logic [ADDR_W_D-1:0] addr;
    logic pred;
  } entry_t;
endpackage

// File: rtl/bp_track_fifo.sv
// bp_track_fifo: in-order synchronous FIFO; clear empties it and drops a same-cycle push
module bp_track_fifo #(
  parameter int W = 4,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic         pop,
  input  logic         clear,
  input  logic [W-1:0] din,
  output logic         full,
  output logic         empty,
  output logic [W-1:0] head
);
  localparam int AW = $clog2(DEPTH);
  logic [AW:0] wr_ptr, rd_ptr;
  logic [W-1:0] mem [DEPTH];
  logic wr_en;
  assign wr_en = push && !clear;
  assign full = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign empty = wr_ptr == rd_ptr;
  assign head = mem[rd_ptr[AW-1:0]];
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (clear) rd_ptr <= wr_ptr;
      else if (pop) rd_ptr <= rd_ptr + 1'b1;
    end
  end
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr[AW-1:0]] <= din;
  end
endmodule

// File: rtl/bp_update_controller.sv
// bp_update_controller: tracks issued predictions, drives predictor updates and mispredict flushes.
// Statistics counters exist only when BP_STATS_EN is defined; otherwise they read 0.
module bp_update_controller
  import bp_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_D,
  parameter int DEPTH = DEPTH_D,
  parameter int CNT_W = CNT_W_D
) (
  input  logic              CLOCK,
  input  logic              INIT,
  input  logic              FETCH_VALID,
  input  logic [ADDR_W-1:0] FETCH_ADDR,
  output logic              FETCH_READY,
  output logic              PREDICT_TAKEN,
  output logic [ADDR_W-1:0] PRED_ADDR,
  input  logic              PRED_IN,
  input  logic              RES_VALID,
  input  logic              RES_OUTCOME,
  output logic              UPD_VALID,
  output logic [ADDR_W-1:0] UPD_ADDR,
  output logic              UPD_OUTCOME,
  output logic              FLUSH,
  output logic              RES_ERR,
  output logic [CNT_W-1:0]  RESOLVED,
  output logic [CNT_W-1:0]  MISPREDICTS
);
  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic pred;
  } ent_t;
  state_t state, state_nx;
  ent_t head, din;
  logic full, empty, push, pop, mis, clear;
  assign PRED_ADDR = FETCH_ADDR;
  assign PREDICT_TAKEN = PRED_IN;
  assign din = '{addr: FETCH_ADDR, pred: PRED_IN};
  always_comb begin
    FETCH_READY = (state == RUN) && !full;
    push = FETCH_VALID && FETCH_READY;
    pop = RES_VALID && !empty && (state == RUN);
    mis = head.pred != RES_OUTCOME;
    clear = pop && mis;
    state_nx = clear ? RECOVER : RUN;
  end
  bp_track_fifo #(.W($bits(ent_t)), .DEPTH(DEPTH)) u_fifo (
    .clk(CLOCK),
    .rst(INIT),
    .push(push),
    .pop(pop),
    .clear(clear),
    .din(din),
    .full(full),
    .empty(empty),
    .head(head)
  );
  always_ff @(posedge CLOCK) begin
    if (INIT) begin
      state <= RUN;
      UPD_VALID <= 1'b0;
      UPD_ADDR <= '0;
      UPD_OUTCOME <= 1'b0;
      FLUSH <= 1'b0;
      RES_ERR <= 1'b0;
    end else begin
      state <= state_nx;
      UPD_VALID <= pop;
      FLUSH <= clear;
      RES_ERR <= RES_ERR || (RES_VALID && !pop);
      if (pop) begin
        UPD_ADDR <= head.addr;
        UPD_OUTCOME <= RES_OUTCOME;
      end
    end
  end
`ifdef BP_STATS_EN
  always_ff @(posedge CLOCK) begin
    if (INIT) begin
      RESOLVED <= '0;
      MISPREDICTS <= '0;
    end else begin
      if (pop && !(&RESOLVED)) RESOLVED <= RESOLVED + 1'b1;
      if (clear && !(&MISPREDICTS)) MISPREDICTS <= MISPREDICTS + 1'b1;
    end
  end
`else
  assign RESOLVED = '0;
  assign MISPREDICTS = '0;
`endif
endmodule

// File: tb/tb_bp_update_controller.sv
// tb_bp_update_controller: directed checks of push/pop, updates, flush, error flag, reset and counters
module tb_bp_update_controller;
`ifdef BP_STATS_EN
  localparam bit ST = 1'b1;
  localparam int CW = 8;
`else
  localparam bit ST = 1'b0;
  localparam int CW = 16;
`endif
  logic clk = 0, rst, fetch_valid, fetch_ready, predict_taken, pred_in;
  logic res_valid, res_outcome, upd_valid, upd_outcome, flush, res_err;
  logic [2:0] fetch_addr, pred_addr, upd_addr;
  logic [CW-1:0] resolved, mispredicts;
  int tests = 0, fails = 0;
  always #5 clk = ~clk;
  bp_update_controller #(.ADDR_W(3), .DEPTH(4), .CNT_W(CW)) dut (
    .CLOCK(clk), .INIT(rst), .FETCH_VALID(fetch_valid), .FETCH_ADDR(fetch_addr),
    .FETCH_READY(fetch_ready), .PREDICT_TAKEN(predict_taken), .PRED_ADDR(pred_addr),
    .PRED_IN(pred_in), .RES_VALID(res_valid), .RES_OUTCOME(res_outcome),
    .UPD_VALID(upd_valid), .UPD_ADDR(upd_addr), .UPD_OUTCOME(upd_outcome),
    .FLUSH(flush), .RES_ERR(res_err), .RESOLVED(resolved), .MISPREDICTS(mispredicts)
  );
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic init;
    rst = 1; fetch_valid = 0; fetch_addr = 0; pred_in = 0; res_valid = 0; res_outcome = 0;
    tick;
    rst = 0;
  endtask
  task automatic push(input logic [2:0] a, input logic p);
    fetch_valid = 1; fetch_addr = a; pred_in = p;
    tick;
    fetch_valid = 0;
  endtask
  task automatic resolve(input logic o);
    res_valid = 1; res_outcome = o;
    tick;
    res_valid = 0;
  endtask
  initial begin
    logic [2:0] seq [4];
    seq[0] = 3'd1; seq[1] = 3'd2; seq[2] = 3'd1; seq[3] = 3'd2;
    init;
    chk("rst_upd_valid", upd_valid, 0);
    chk("rst_upd_addr", upd_addr, 0);
    chk("rst_upd_outcome", upd_outcome, 0);
    chk("rst_flush", flush, 0);
    chk("rst_res_err", res_err, 0);
    chk("rst_resolved", resolved, 0);
    chk("rst_mispredicts", mispredicts, 0);
    chk("rst_ready", fetch_ready, 1);
    // single mispredict
    fetch_valid = 1; fetch_addr = 3'd1; pred_in = 0;
    #1;
    chk("t1_pred_addr", pred_addr, 1);
    chk("t1_predict", predict_taken, 0);
    tick;
    fetch_valid = 0;
    resolve(1);
    chk("t1_upd_valid", upd_valid, 1);
    chk("t1_upd_addr", upd_addr, 1);
    chk("t1_upd_outcome", upd_outcome, 1);
    chk("t1_flush", flush, 1);
    chk("t1_ready_recover", fetch_ready, 0);
    chk("t1_mispredicts", mispredicts, ST ? 1 : 0);
    chk("t1_resolved", resolved, ST ? 1 : 0);
    tick;
    chk("t1_flush_off", flush, 0);
    chk("t1_upd_off", upd_valid, 0);
    chk("t1_ready_back", fetch_ready, 1);
    // fill, then three correct resolves
    init;
    for (int i = 0; i < 4; i++) push(seq[i], 1);
    chk("t2_full_ready", fetch_ready, 0);
    for (int i = 0; i < 3; i++) begin
      resolve(1);
      chk("t2_upd_valid", upd_valid, 1);
      chk("t2_upd_addr", upd_addr, seq[i]);
      chk("t2_flush", flush, 0);
    end
    chk("t2_resolved", resolved, ST ? 3 : 0);
    chk("t2_mispredicts", mispredicts, 0);
    tick;
    chk("t2_upd_off", upd_valid, 0);
    // mispredict with a same-cycle wrong-path push
    init;
    push(3, 1); push(4, 1); push(5, 1);
    fetch_valid = 1; fetch_addr = 3'd6; pred_in = 1; res_valid = 1; res_outcome = 0;
    tick;
    fetch_valid = 0; res_valid = 0;
    chk("t3_flush", flush, 1);
    chk("t3_upd_addr", upd_addr, 3);
    chk("t3_upd_outcome", upd_outcome, 0);
    chk("t3_ready", fetch_ready, 0);
    tick;
    chk("t3_flush_once", flush, 0);
    chk("t3_err_clear", res_err, 0);
    resolve(1);
    chk("t3_no_upd", upd_valid, 0);
    chk("t3_res_err", res_err, 1);
    tick;
    chk("t3_err_sticky", res_err, 1);
    // full FIFO, then streaming across pointer wrap
    init;
    for (int i = 0; i < 4; i++) push(3'(i), 1);
    fetch_valid = 1; fetch_addr = 3'd4; pred_in = 1; res_valid = 1; res_outcome = 1;
    #1;
    chk("t4_full_ready", fetch_ready, 0);
    tick;
    chk("t4_first_pop", upd_addr, 0);
    for (int i = 0; i < 10; i++) begin
      fetch_addr = 3'(4 + i);
      #1;
      chk("t4_stream_ready", fetch_ready, 1);
      tick;
      chk("t4_stream_upd", upd_valid, 1);
      chk("t4_stream_addr", upd_addr, (1 + i) % 8);
    end
    fetch_valid = 0;
    for (int i = 0; i < 3; i++) begin
      tick;
      chk("t4_drain_addr", upd_addr, (3 + i) % 8);
    end
    chk("t4_no_err", res_err, 0);
    tick;
    res_valid = 0;
    chk("t4_drained", upd_valid, 0);
    chk("t4_err", res_err, 1);
    // INIT with entries in flight beats a same-cycle mispredict
    init;
    push(2, 1); push(7, 1);
    rst = 1; res_valid = 1; res_outcome = 0;
    tick;
    rst = 0; res_valid = 0;
    chk("t5_upd_valid", upd_valid, 0);
    chk("t5_flush", flush, 0);
    chk("t5_upd_addr", upd_addr, 0);
    chk("t5_ready", fetch_ready, 1);
    chk("t5_resolved", resolved, 0);
    resolve(1);
    chk("t5_empty_upd", upd_valid, 0);
    chk("t5_empty_err", res_err, 1);
    // counter saturation
    init;
    for (int i = 0; i < 300; i++) begin
      push(1, 0);
      resolve(1);
      tick;
    end
    chk("t6_mispredicts", mispredicts, ST ? {CW{1'b1}} : 0);
    chk("t6_resolved", resolved, ST ? {CW{1'b1}} : 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
